// File: rtl/turf_keys_pkg.sv
// Shared constants and types for the PS/2 key decoder: scan codes, key codes,
// FSM state encodings and the scan-code-to-key mapping.
package turf_keys_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [4:0] KEY_IDLE       = 5'd31;
  localparam logic [4:0] KEY_RESET_GAME = 5'd16;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef enum logic [1:0] {NORM, EXT, BRK, EXT_BRK} pfx_state_t;

  typedef struct packed {
    logic       hit;
    logic [4:0] code;
  } key_map_t;

  function automatic logic [4:0] key_code(input logic [1:0] player, input logic [1:0] dir);
    return {1'b0, player, dir};
  endfunction

  // Extended (E0) codes only map the arrow cluster; everything else is ignored.
  function automatic key_map_t map_key(input logic ext, input logic [7:0] sc);
    key_map_t r;
    r.hit  = 1'b1;
    r.code = KEY_IDLE;
    if (ext) begin
      case (sc)
        SC_UP:    r.code = key_code(2'd1, DIR_UP);
        SC_DOWN:  r.code = key_code(2'd1, DIR_DOWN);
        SC_LEFT:  r.code = key_code(2'd1, DIR_LEFT);
        SC_RIGHT: r.code = key_code(2'd1, DIR_RIGHT);
        default:  r.hit  = 1'b0;
      endcase
    end else begin
      case (sc)
        SC_W:     r.code = key_code(2'd0, DIR_UP);
        SC_S:     r.code = key_code(2'd0, DIR_DOWN);
        SC_A:     r.code = key_code(2'd0, DIR_LEFT);
        SC_D:     r.code = key_code(2'd0, DIR_RIGHT);
        SC_I:     r.code = key_code(2'd2, DIR_UP);
        SC_K:     r.code = key_code(2'd2, DIR_DOWN);
        SC_J:     r.code = key_code(2'd2, DIR_LEFT);
        SC_L:     r.code = key_code(2'd2, DIR_RIGHT);
        SC_KP8:   r.code = key_code(2'd3, DIR_UP);
        SC_KP5:   r.code = key_code(2'd3, DIR_DOWN);
        SC_KP4:   r.code = key_code(2'd3, DIR_LEFT);
        SC_KP6:   r.code = key_code(2'd3, DIR_RIGHT);
        SC_SPACE: r.code = KEY_RESET_GAME;
        default:  r.hit  = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key outputs of the key decoder.
interface ps2_key_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [4:0] KEY_PRESSED;
  logic       key_strobe;
  logic       frame_err;

  modport master (output PS2_CLK, PS2_DAT, input KEY_PRESSED, key_strobe, frame_err);
  modport slave  (input PS2_CLK, PS2_DAT, output KEY_PRESSED, key_strobe, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchronizers, falling-edge detect, 11-bit frame FSM
// with odd-parity and stop checks, and an idle timeout that aborts stalled frames.
module ps2_rx_frame
  import turf_keys_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, fall, clk_edge, timeout;
  logic [TW-1:0]          timer_q;
  logic [2:0]             cnt_q;
  logic                   par_ok_q;
  logic                   valid_d, err_d;
  frame_state_t           state_q, state_d;

  // Lines idle high, so the chains reset high to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_s;
  assign clk_edge = clk_prev ^ clk_s;
  assign timeout  = (state_q != IDLE) && (timer_q == TW'(TIMEOUT_CYC)) && !clk_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat_s) state_d = DATA;
        DATA:    if (cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = 1'b0;
    err_d   = timeout;
    if (fall && !timeout) begin
      case (state_q)
        IDLE: err_d = dat_s;
        STOP: begin
          valid_d = dat_s & par_ok_q;
          err_d   = ~(dat_s & par_ok_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q    <= '0;
      cnt_q      <= '0;
      par_ok_q   <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state_q == IDLE || clk_edge) begin
        timer_q <= '0;
      end else if (timer_q != TW'(TIMEOUT_CYC)) begin
        timer_q <= timer_q + TW'(1);
      end
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (state_q == DATA && fall) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (state_q == PARITY && fall) begin
        par_ok_q <= (^rx_byte) ^ dat_s;
      end
      byte_valid <= valid_d;
      frame_err  <= err_d;
    end
  end

  // LSB arrives first, so bits enter at the top and shift down.
  always_ff @(posedge clk) begin
    if (state_q == DATA && fall) begin
      rx_byte <= {dat_s, rx_byte[7:1]};
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard front end: tracks E0/F0 prefixes and maps keys to KEY_PRESSED.
// Build option KEY_REPEAT_FILTER_EN suppresses key_strobe on typematic repeats.
module ps2_key_decoder
  import turf_keys_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT_CYC = 10000,
  parameter logic [4:0] KEY_IDLE    = turf_keys_pkg::KEY_IDLE
) (
  input logic               CLOCK_50,
  input logic               reset,
  ps2_key_decoder_if.slave  bus
);

  logic [7:0] rx_byte;
  logic       byte_valid, rx_err;
  pfx_state_t pfx_q, pfx_d;
  logic       ext, brk, is_prefix, key_ev;
  key_map_t   km;
  logic [4:0] key_q;
  logic       strobe_q, err_q;

  ps2_rx_frame #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk        (CLOCK_50),
    .rst        (reset),
    .ps2_clk    (bus.PS2_CLK),
    .ps2_dat    (bus.PS2_DAT),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_err)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pfx_q <= NORM;
    end else begin
      pfx_q <= pfx_d;
    end
  end

  always_comb begin
    pfx_d = pfx_q;
    if (rx_err) begin
      pfx_d = NORM;
    end else if (byte_valid) begin
      if (rx_byte == SC_E0 && pfx_q == NORM)      pfx_d = EXT;
      else if (rx_byte == SC_F0 && pfx_q == NORM) pfx_d = BRK;
      else if (rx_byte == SC_F0 && pfx_q == EXT)  pfx_d = EXT_BRK;
      else                                        pfx_d = NORM;
    end
  end

  always_comb begin
    ext       = (pfx_q == EXT) || (pfx_q == EXT_BRK);
    brk       = (pfx_q == BRK) || (pfx_q == EXT_BRK);
    is_prefix = ((rx_byte == SC_E0) && (pfx_q == NORM)) ||
                ((rx_byte == SC_F0) && (pfx_q == NORM || pfx_q == EXT));
    key_ev    = byte_valid && !is_prefix;
  end

  assign km = map_key(ext, rx_byte);

  // Output stage: one cycle after byte_valid, aligned with frame_err.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_q    <= KEY_IDLE;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= rx_err;
      if (key_ev && km.hit) begin
        if (brk) begin
          if (km.code == key_q) key_q <= KEY_IDLE;
        end
`ifdef KEY_REPEAT_FILTER_EN
        else if (km.code != key_q) begin
          key_q    <= km.code;
          strobe_q <= 1'b1;
        end
`else
        else begin
          key_q    <= km.code;
          strobe_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.KEY_PRESSED = key_q;
  assign bus.key_strobe  = strobe_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-bangs PS/2 frames and checks decoded keys,
// strobes and frame errors against hand-computed values.
module tb_ps2_key_decoder;

  logic CLOCK_50;
  logic reset;
  int   checks;
  int   errors;
  int   strobe_cnt;
  int   err_cnt;
  int   exp_strobes;

  ps2_key_decoder_if bus ();

  ps2_key_decoder dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (bus.key_strobe === 1'b1) strobe_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One PS/2 bit: data set up, clock low for 10 cycles, high for 10 cycles.
  task automatic ps2_bit(input logic d);
    bus.PS2_DAT = d;
    repeat (5) @(posedge CLOCK_50);
    #1 bus.PS2_CLK = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    #1 bus.PS2_CLK = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par_flip, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
    repeat (20) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    strobe_cnt  = 0;
    err_cnt     = 0;
    reset       = 1'b1;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset_key", bus.KEY_PRESSED, 31);
    check("reset_strobe", bus.key_strobe, 0);
    check("reset_err", bus.frame_err, 0);
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    #1;

    // Test 1: make 1D with explicit latency check on the stop bit, then break.
    send_bits(8'h1D, 1'b0, 10);
    bus.PS2_DAT = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1 bus.PS2_CLK = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("lat_key_early", bus.KEY_PRESSED, 31);
    check("lat_strobe_early", bus.key_strobe, 0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("lat_key", bus.KEY_PRESSED, 0);
    check("lat_strobe", bus.key_strobe, 1);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("strobe_width", bus.key_strobe, 0);
    repeat (6) @(posedge CLOCK_50);
    #1 bus.PS2_CLK = 1'b1;
    repeat (25) @(posedge CLOCK_50);
    #1;
    send_byte(8'hF0);
    send_byte(8'h1D);
    check("t1_break_key", bus.KEY_PRESSED, 31);
    check("t1_strobes", strobe_cnt, 1);
    check("t1_errs", err_cnt, 0);

    // Test 2: E0 75 is player 2 up, plain 75 is keypad player 4 up.
    send_byte(8'hE0);
    send_byte(8'h75);
    check("t2_ext_key", bus.KEY_PRESSED, 4);
    send_byte(8'h75);
    check("t2_kp_key", bus.KEY_PRESSED, 12);
    send_byte(8'hE0);
    send_byte(8'h1D);
    check("t2_e0_nonarrow_key", bus.KEY_PRESSED, 12);
    check("t2_strobes", strobe_cnt, 3);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("t2_break_key", bus.KEY_PRESSED, 31);

    // Test 3: bad parity, then a start bit of 1.
    send_bits(8'h23, 1'b1, 11);
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("t3_par_errs", err_cnt, 1);
    check("t3_par_key", bus.KEY_PRESSED, 31);
    check("t3_par_strobes", strobe_cnt, 3);
    ps2_bit(1'b1);
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("t3_start_errs", err_cnt, 2);

    // Test 4: clock stalls after 5 data bits.
    send_bits(8'h55, 1'b0, 6);
    repeat (5000) @(posedge CLOCK_50);
    #1;
    check("t4_no_early_timeout", err_cnt, 2);
    repeat (6000) @(posedge CLOCK_50);
    #1;
    check("t4_timeout_errs", err_cnt, 3);
    send_byte(8'h29);
    check("t4_space_key", bus.KEY_PRESSED, 16);
    check("t4_strobes", strobe_cnt, 4);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("t4_break_key", bus.KEY_PRESSED, 31);

    // Test 5: last press wins; releasing the older key keeps the newer one.
    send_byte(8'h1D);
    check("t5_make_w", bus.KEY_PRESSED, 0);
    send_byte(8'h42);
    check("t5_make_k", bus.KEY_PRESSED, 9);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check("t5_break_w", bus.KEY_PRESSED, 9);
    send_byte(8'hF0);
    send_byte(8'h42);
    check("t5_break_k", bus.KEY_PRESSED, 31);
    check("t5_strobes", strobe_cnt, 6);

    // Test 6: typematic repeat, then reset in the middle of a frame.
`ifdef KEY_REPEAT_FILTER_EN
    exp_strobes = 7;
`else
    exp_strobes = 8;
`endif
    send_byte(8'h43);
    send_byte(8'h43);
    check("t6_repeat_key", bus.KEY_PRESSED, 8);
    check("t6_repeat_strobes", strobe_cnt, exp_strobes);
    send_bits(8'h1C, 1'b0, 5);
    @(posedge CLOCK_50);
    #1 reset = 1'b1;
    @(negedge CLOCK_50);
    check("t6_rst_key", bus.KEY_PRESSED, 31);
    check("t6_rst_strobe", bus.key_strobe, 0);
    check("t6_rst_err", bus.frame_err, 0);
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (20) @(posedge CLOCK_50);
    #1;
    send_byte(8'h1C);
    check("t6_after_rst_key", bus.KEY_PRESSED, 2);
    check("t6_after_rst_strobes", strobe_cnt, exp_strobes + 1);
    check("t6_after_rst_errs", err_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
